dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests issued by the core's MEM stage. It is the memory-side end of the MEM-stage request/response interface.
- Accepts one request at a time over a valid/ready handshake and models a fixed access latency.
- Performs byte/half/word reads and writes with sign/zero extension, then returns a response over a second valid/ready handshake.
- Used in simulation top-levels and in FPGA builds as on-chip data RAM.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; byte address range is 0 .. DEPTH_WORDS*4-1.
- LATENCY, 2, cycles from request acceptance to resp_valid_o assertion; legal range 1..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts the response.
- resp_rdata_o  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_error_o  out  1  misaligned, illegal-size or out-of-range access.

Behaviour:
- Reset: rst_i is synchronous, active-high, sampled on the clk_i rising edge.
  - Forces state IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_error_o=0, latency counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o (the accept edge, cycle T), latch we/addr/size/unsigned/wdata.
  - LATENCY==1: go to RESP. Otherwise load counter with LATENCY-2 and go to WAIT.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; when counter==0, go to RESP.
  - resp_valid_o is first high in cycle T+LATENCY.
- Access timing: memory read/write happens on the edge that enters RESP.
  - resp_rdata_o and resp_error_o are registered on that same edge.
  - The array is written only on that edge.
- RESP:
  - resp_valid_o=1, req_ready_o=0.
  - resp_rdata_o and resp_error_o stay stable until handshake.
  - On resp_valid_o & resp_ready_i: go to IDLE and clear resp_valid_o.
  - Throughput is one request per LATENCY+1 cycles when resp_ready_i=1. There is no accept in the same cycle as a response handshake.
- req_* inputs are ignored outside IDLE. Requests presented there are not latched and not lost silently: req_ready_o=0 tells the requester to hold.
- Error detection:
  - Conditions: half with addr[0]!=0; word with addr[1:0]!=0; size 11; addr >= DEPTH_WORDS*4.
  - On error: no array write, resp_rdata_o=0, resp_error_o=1.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
- Stores: byte-enable merge into the addressed word.
  - Byte writes lane addr[1:0].
  - Half writes lanes {addr[1],0} and {addr[1],1}.
  - Word writes all four lanes.
  - Other bytes are unchanged. Memory is little-endian.
- Loads:
  - Extract the lane(s), right-align, then sign-extend (req_unsigned_i=0) or zero-extend.
  - Word loads ignore req_unsigned_i.
- Reset mid-operation (in WAIT or RESP):
  - A pending request is discarded.
  - A store still in WAIT never reaches the array.
  - Any outstanding response is dropped.
- rst_i and req_valid_i high in the same cycle: reset wins, nothing is accepted.

Test Plan:
- Reset, then SW 0xDEADBEEF to 0x10, then LW 0x10 → resp_rdata_o=0xDEADBEEF, resp_error_o=0. resp_valid_o first high exactly 2 cycles after each accept edge; req_ready_o=0 during WAIT and RESP.
- After the above, SB 0x80 to 0x13 → LB 0x13=0xFFFFFF80, LBU 0x13=0x00000080, LW 0x10=0x80ADBEEF. SH 0x1234 to 0x10 → LW 0x10=0x80AD1234, LH 0x12=0xFFFF80AD.
- LH 0x11 → error=1, rdata=0. SW 0x1000 (DEPTH 1024) → error=1, array unchanged. size=11 → error=1.
- Backpressure: complete a load, then hold resp_ready_i=0 for 5 cycles while driving req_valid_i=1 → resp_valid_o, rdata and error stable; req_ready_o=0; the pending request is accepted only after the response handshake returns the FSM to IDLE.
- Assert rst_i for 1 cycle while a SW 0x11111111 to 0x20 is in WAIT (prior value 0x22222222) → outputs return to reset values; LW 0x20 afterwards returns 0x22222222.
- LATENCY=1 instance: accept at T → resp_valid_o at T+1. Back-to-back loads with resp_ready_i=1 → one accept every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MEM-stage load/store interface.
// Accepts one request at a time, waits a fixed LATENCY, then performs the
// byte/half/word access and holds the response until the consumer takes it.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_valid_i/ready_o  request handshake
//   req_we_i             1 = store, 0 = load
//   req_addr_i           byte address
//   req_size_i           00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i       loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata_i          store data, right-aligned
//   resp_valid_o/ready_i response handshake
//   resp_rdata_o         extended load data (0 for stores and errors)
//   resp_error_o         misaligned, illegal size or out of range
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIM = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } req_t;

    state_e      state_q;
    req_t        req_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS];

    req_t        live;
    req_t        acc;
    logic        accept;
    logic        enter_resp;
    logic        err_d;
    logic [31:0] rdata_d;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] wd_lane;
    logic        mem_we;

    assign live = '{we: req_we_i, addr: req_addr_i, size: req_size_i,
                    uns: req_unsigned_i, wdata: req_wdata_i};

    // With LATENCY==1 the access happens on the accept edge itself, before
    // the request has been latched, so the live inputs are used in IDLE.
    assign acc = (state_q == IDLE) ? live : req_q;

    assign accept     = (state_q == IDLE) && req_valid_i && req_ready_q;
    assign enter_resp = (state_q == IDLE) ? (accept && (LATENCY == 1))
                                          : ((state_q == WAIT) && (cnt_q == 4'd0));

    always_comb begin
        err_d = 1'b0;
        case (acc.size)
            2'b01:   err_d = acc.addr[0];
            2'b10:   err_d = (acc.addr[1:0] != 2'b00);
            2'b11:   err_d = 1'b1;
            default: err_d = 1'b0;
        endcase
        if (acc.addr >= ADDR_LIM) err_d = 1'b1;
    end

    assign idx     = acc.addr[AW+1:2];
    assign word    = mem[idx];
    assign shifted = word >> {acc.addr[1:0], 3'b000};

    always_comb begin
        load_val = shifted;
        case (acc.size)
            2'b00:   load_val = acc.uns ? {24'd0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = acc.uns ? {16'd0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = word;
        endcase
    end

    assign rdata_d = (err_d || acc.we) ? 32'd0 : load_val;

    always_comb begin
        be = 4'b0000;
        case (acc.size)
            2'b00:   be = 4'b0001 << acc.addr[1:0];
            2'b01:   be = 4'b0011 << {acc.addr[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign wd_lane = acc.wdata << {acc.addr[1:0], 3'b000};
    // Reset on the RESP-entry edge must also suppress the write.
    assign mem_we  = enter_resp && !rst_i && acc.we && !err_d;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd_lane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_q        <= '0;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q       <= live;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            rdata_q      <= rdata_d;
                            err_q        <= err_d;
                        end else begin
                            cnt_q   <= 4'(LATENCY - 2);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (enter_resp) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= rdata_d;
                        err_q        <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_error_o = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance share the
// request payload; a byte-array model predicts every response.
module tb_dmem_responder;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv, rr, rdy, vld, eo;
    logic        we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic [31:0] rdo [2];

    int checks   = 0;
    int failures = 0;

    bit   [7:0]  mm [2][4096];
    logic [31:0] exp_rd [2];
    logic        exp_er [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rv[0]), .req_ready_o(rdy[0]),
        .req_we_i(we), .req_addr_i(addr), .req_size_i(size), .req_unsigned_i(uns),
        .req_wdata_i(wdata), .resp_valid_o(vld[0]), .resp_ready_i(rr[0]),
        .resp_rdata_o(rdo[0]), .resp_error_o(eo[0]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(rv[1]), .req_ready_o(rdy[1]),
        .req_we_i(we), .req_addr_i(addr), .req_size_i(size), .req_unsigned_i(uns),
        .req_wdata_i(wdata), .resp_valid_o(vld[1]), .resp_ready_i(rr[1]),
        .resp_rdata_o(rdo[1]), .resp_error_o(eo[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: memory as a byte array, rules applied directly.
    task automatic model(input int d, input bit w, input logic [31:0] a,
                         input logic [1:0] sz, input bit u, input logic [31:0] wd);
        bit          e;
        int          n;
        logic [31:0] v;
        e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
            || (a >= 32'd4096);
        exp_er[d] = e;
        exp_rd[d] = 32'd0;
        if (!e) begin
            n = 1 << sz;
            if (w) begin
                for (int i = 0; i < n; i++) mm[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][int'(a) + i];
                if (sz == 2'b00 && !u && v[7])  v = v | 32'hFFFF_FF00;
                if (sz == 2'b01 && !u && v[15]) v = v | 32'hFFFF_0000;
                exp_rd[d] = v;
            end
        end
    endtask

    task automatic issue(input int d, input bit w, input logic [31:0] a,
                         input logic [1:0] sz, input bit u, input logic [31:0] wd);
        model(d, w, a, sz, u, wd);
        @(negedge clk);
        we = w; addr = a; size = sz; uns = u; wdata = wd;
        rv[d] = 1'b1;
        chk("rdy_idle", 32'(rdy[d]), 32'd1);
        @(posedge clk);
        #1 rv[d] = 1'b0;
    endtask

    task automatic wait_resp(input int d);
        int k;
        k = 1;
        @(negedge clk);
        while (!vld[d] && k < 20) begin
            chk("rdy_wait", 32'(rdy[d]), 32'd0);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'((d == 0) ? LAT0 : LAT1));
        chk("rdy_resp", 32'(rdy[d]), 32'd0);
        chk("rdata", rdo[d], exp_rd[d]);
        chk("error", 32'(eo[d]), 32'(exp_er[d]));
    endtask

    task automatic ack(input int d);
        rr[d] = 1'b1;
        @(posedge clk);
        #1 rr[d] = 1'b0;
        chk("vld_clr", 32'(vld[d]), 32'd0);
    endtask

    task automatic xact(input int d, input bit w, input logic [31:0] a,
                        input logic [1:0] sz, input bit u, input logic [31:0] wd);
        issue(d, w, a, sz, u, wd);
        wait_resp(d);
        ack(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int          acc;
        logic [31:0] ra;
        rst = 1'b1; rv = '0; rr = '0;
        we = 1'b0; addr = '0; size = '0; uns = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", 32'(rdy[d]), 32'd1);
            chk("rst_vld", 32'(vld[d]), 32'd0);
            chk("rst_rd", rdo[d], 32'd0);
            chk("rst_err", 32'(eo[d]), 32'd0);
        end
        rst = 1'b0;

        // Directed sequence on the LATENCY=2 instance
        xact(0, 1, 32'h00, 2'b10, 0, 32'hA5A5_A5A5);
        xact(0, 1, 32'h10, 2'b10, 0, 32'hDEAD_BEEF);
        xact(0, 0, 32'h10, 2'b10, 0, 0);
        chk("tp_lw", rdo[0], 32'hDEAD_BEEF);
        xact(0, 1, 32'h13, 2'b00, 0, 32'h80);
        xact(0, 0, 32'h13, 2'b00, 0, 0);
        chk("tp_lb", rdo[0], 32'hFFFF_FF80);
        xact(0, 0, 32'h13, 2'b00, 1, 0);
        chk("tp_lbu", rdo[0], 32'h0000_0080);
        xact(0, 0, 32'h10, 2'b10, 0, 0);
        chk("tp_lw2", rdo[0], 32'h80AD_BEEF);
        xact(0, 1, 32'h10, 2'b01, 0, 32'h1234);
        xact(0, 0, 32'h10, 2'b10, 0, 0);
        chk("tp_lw3", rdo[0], 32'h80AD_1234);
        xact(0, 0, 32'h12, 2'b01, 0, 0);
        chk("tp_lh", rdo[0], 32'hFFFF_80AD);
        xact(0, 0, 32'h11, 2'b01, 0, 0);
        chk("tp_mis_err", 32'(eo[0]), 32'd1);
        xact(0, 1, 32'h1000, 2'b10, 0, 32'h1357_9BDF);
        chk("tp_oor_err", 32'(eo[0]), 32'd1);
        xact(0, 0, 32'h00, 2'b10, 0, 0);
        chk("tp_oor_keep", rdo[0], 32'hA5A5_A5A5);
        xact(0, 0, 32'h14, 2'b11, 0, 0);
        chk("tp_sz3_err", 32'(eo[0]), 32'd1);

        // Backpressure with a new request waiting
        issue(0, 0, 32'h10, 2'b10, 0, 0);
        wait_resp(0);
        we = 1'b0; addr = 32'h13; size = 2'b00; uns = 1'b1; rv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld", 32'(vld[0]), 32'd1);
            chk("bp_rd", rdo[0], 32'h80AD_1234);
            chk("bp_err", 32'(eo[0]), 32'd0);
            chk("bp_rdy", 32'(rdy[0]), 32'd0);
        end
        ack(0);
        issue(0, 0, 32'h13, 2'b00, 1, 0);
        wait_resp(0);
        chk("bp_next", rdo[0], 32'h0000_0080);
        ack(0);

        // Reset while a store waits
        xact(0, 1, 32'h20, 2'b10, 0, 32'h2222_2222);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; size = 2'b10; uns = 1'b0; wdata = 32'h1111_1111;
        rv[0] = 1'b1;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mrst_rdy", 32'(rdy[0]), 32'd1);
        chk("mrst_vld", 32'(vld[0]), 32'd0);
        chk("mrst_rd", rdo[0], 32'd0);
        chk("mrst_err", 32'(eo[0]), 32'd0);
        xact(0, 0, 32'h20, 2'b10, 0, 0);
        chk("mrst_keep", rdo[0], 32'h2222_2222);

        // Reset and valid together: nothing accepted
        @(negedge clk);
        we = 1'b1; addr = 32'h20; size = 2'b10; wdata = 32'h9999_9999;
        rst = 1'b1; rv[0] = 1'b1;
        @(posedge clk);
        #1 begin rst = 1'b0; rv[0] = 1'b0; end
        @(negedge clk);
        chk("rstv_rdy", 32'(rdy[0]), 32'd1);
        chk("rstv_vld", 32'(vld[0]), 32'd0);
        xact(0, 0, 32'h20, 2'b10, 0, 0);

        // LATENCY=1 instance: single transaction then back-to-back loads
        xact(1, 1, 32'h00, 2'b10, 0, 32'h0BAD_F00D);
        xact(1, 0, 32'h00, 2'b10, 0, 0);
        we = 1'b0; addr = 32'h00; size = 2'b10; uns = 1'b0;
        rr[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b1;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (rdy[1]) acc++;
            chk("b2b_alt", 32'(vld[1]), 32'(!rdy[1]));
            @(negedge clk);
        end
        rv[1] = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd10);
        @(posedge clk);
        #1 rr[1] = 1'b0;

        // Fill a window, then random traffic on both instances
        for (int w = 0; w < 64; w++) begin
            xact(0, 1, 32'(w * 4), 2'b10, 0, $urandom);
            xact(1, 1, 32'(w * 4), 2'b10, 0, $urandom);
        end
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       ra = 32'h1000 + $urandom_range(0, 255);
                1:       ra = $urandom;
                default: ra = 32'($urandom_range(0, 255));
            endcase
            xact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
